// File: rtl/axi_lite_master.sv
// Single-outstanding AXI-Lite master: one command in flight, response held until rsp_ready.
// Write latency is cmd accept -> AW/W -> B -> rsp_valid; cmd_ready is low from accept until the response is consumed.
module axi_lite_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic                  M_AXI_ACLK,
  input  logic                  M_AXI_ARESETN,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  input  logic [DATA_W/8-1:0]   cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic [15:0]           err_count,
  output logic [ADDR_W-1:0]     M_AXI_AWADDR,
  output logic                  M_AXI_AWVALID,
  input  logic                  M_AXI_AWREADY,
  output logic [DATA_W-1:0]     M_AXI_WDATA,
  output logic [DATA_W/8-1:0]   M_AXI_WSTRB,
  output logic                  M_AXI_WVALID,
  input  logic                  M_AXI_WREADY,
  input  logic [1:0]            M_AXI_BRESP,
  input  logic                  M_AXI_BVALID,
  output logic                  M_AXI_BREADY,
  output logic [ADDR_W-1:0]     M_AXI_ARADDR,
  output logic                  M_AXI_ARVALID,
  input  logic                  M_AXI_ARREADY,
  input  logic [DATA_W-1:0]     M_AXI_RDATA,
  input  logic [1:0]            M_AXI_RRESP,
  input  logic                  M_AXI_RVALID,
  output logic                  M_AXI_RREADY
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4,
    RSP     = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [STRB_W-1:0]   r_wstrb;
  logic                r_aw_done;
  logic                r_w_done;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic [1:0]          r_rsp_resp;
  logic                r_rsp_write;
  logic [15:0]         r_err_count;

  logic w_cmd_hs, w_aw_hs, w_w_hs, w_b_hs, w_r_hs, w_err;

  // All VALID/READY outputs are decoded from registers only, so these have no READY->VALID path.
  assign w_cmd_hs = cmd_ready && cmd_valid;
  assign w_aw_hs  = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_w_hs   = M_AXI_WVALID && M_AXI_WREADY;
  assign w_b_hs   = M_AXI_BREADY && M_AXI_BVALID;
  assign w_r_hs   = M_AXI_RREADY && M_AXI_RVALID;
  assign w_err    = (w_b_hs && (M_AXI_BRESP != 2'b00)) || (w_r_hs && (M_AXI_RRESP != 2'b00));

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) r_state <= IDLE;
    else                r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (cmd_valid) w_next = cmd_write ? WR_REQ : RD_REQ;
      WR_REQ:  if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_next = WR_RESP;
      WR_RESP: if (M_AXI_BVALID) w_next = RSP;
      RD_REQ:  if (M_AXI_ARREADY) w_next = RD_DATA;
      RD_DATA: if (M_AXI_RVALID) w_next = RSP;
      RSP:     if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready     = 1'b0;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_BREADY  = 1'b0;
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;
    rsp_valid     = 1'b0;
    case (r_state)
      IDLE:    cmd_ready = 1'b1;
      WR_REQ: begin
        M_AXI_AWVALID = !r_aw_done;
        M_AXI_WVALID  = !r_w_done;
      end
      WR_RESP: M_AXI_BREADY  = 1'b1;
      RD_REQ:  M_AXI_ARVALID = 1'b1;
      RD_DATA: M_AXI_RREADY  = 1'b1;
      RSP:     rsp_valid     = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= 2'b00;
      r_rsp_write <= 1'b0;
      r_err_count <= 16'd0;
    end else begin
      if (w_cmd_hs) begin
        r_addr    <= cmd_addr;
        r_wdata   <= cmd_wdata;
        r_wstrb   <= cmd_wstrb;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end
      if (w_aw_hs) r_aw_done <= 1'b1;
      if (w_w_hs)  r_w_done  <= 1'b1;
      if (w_b_hs) begin
        r_rsp_resp  <= M_AXI_BRESP;
        r_rsp_rdata <= '0;
        r_rsp_write <= 1'b1;
      end
      if (w_r_hs) begin
        r_rsp_resp  <= M_AXI_RRESP;
        r_rsp_rdata <= M_AXI_RDATA;
        r_rsp_write <= 1'b0;
      end
      if (w_err && (r_err_count != 16'hFFFF)) r_err_count <= r_err_count + 16'd1;
    end
  end

  assign M_AXI_AWADDR = r_addr;
  assign M_AXI_ARADDR = r_addr;
  assign M_AXI_WDATA  = r_wdata;
  assign M_AXI_WSTRB  = r_wstrb;
  assign rsp_rdata    = r_rsp_rdata;
  assign rsp_resp     = r_rsp_resp;
  assign rsp_write    = r_rsp_write;
  assign err_count    = r_err_count;

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master: slave side driven by hand on the falling edge, outputs sampled there too.
module tb_axi_lite_master;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [DATA_W-1:0]   cmd_wdata;
  logic [DATA_W/8-1:0] cmd_wstrb;
  logic                rsp_valid, rsp_ready, rsp_write;
  logic [DATA_W-1:0]   rsp_rdata;
  logic [1:0]          rsp_resp;
  logic [15:0]         err_count;
  logic [ADDR_W-1:0]   awaddr, araddr;
  logic                awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [DATA_W-1:0]   wdata, rdata;
  logic [DATA_W/8-1:0] wstrb;
  logic [1:0]          bresp, rresp;

  int checks = 0;
  int passed = 0;
  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  logic [ADDR_W-1:0]   aw_addr_seen, ar_addr_seen;
  logic [DATA_W-1:0]   w_data_seen;
  logic [DATA_W/8-1:0] w_strb_seen;

  always #5 clk = ~clk;

  axi_lite_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .err_count(err_count),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  // Handshake monitor on the rising edge; tasks clear the counters on the falling edge.
  always @(posedge clk) begin
    if (awvalid && awready) begin aw_cnt++; aw_addr_seen = awaddr; end
    if (wvalid && wready) begin w_cnt++; w_data_seen = wdata; w_strb_seen = wstrb; end
    if (bvalid && bready) b_cnt++;
    if (arvalid && arready) begin ar_cnt++; ar_addr_seen = araddr; end
    if (rvalid && rready) r_cnt++;
  end

  task automatic clear_counts();
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
  endtask

  // Presents one command for a single cycle; returns on the falling edge after acceptance.
  task automatic issue_cmd(input logic wr, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d, input logic [DATA_W/8-1:0] s);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic consume_rsp();
    @(negedge clk); rsp_ready = 1'b1;
    @(negedge clk); rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (cmd_ready !== 1'b1) $display("FAIL rst_cmd_ready got %b exp 1", cmd_ready); else passed++;
    checks++; if ({awvalid, wvalid, bready, arvalid, rready} !== 5'b0) $display("FAIL rst_axi_handshake got %b exp 00000", {awvalid, wvalid, bready, arvalid, rready}); else passed++;
    checks++; if ({rsp_valid, rsp_write, rsp_resp} !== 4'b0) $display("FAIL rst_rsp got %b exp 0000", {rsp_valid, rsp_write, rsp_resp}); else passed++;
    checks++; if (rsp_rdata !== 64'd0 || err_count !== 16'd0) $display("FAIL rst_data_err got %h/%h exp 0/0", rsp_rdata, err_count); else passed++;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) $display("FAIL post_rst_cmd_ready got %b exp 1", cmd_ready); else passed++;
  endtask

  task automatic test_write_basic();
    clear_counts();
    awready = 1'b1; wready = 1'b1;
    issue_cmd(1'b1, 32'h0000_0000, 64'h0000_0000_0000_0010, 8'hFF);
    checks++; if ({awvalid, wvalid, cmd_ready} !== 3'b110) $display("FAIL wr_valids_rise got %b exp 110", {awvalid, wvalid, cmd_ready}); else passed++;
    checks++; if (awaddr !== 32'h0 || wdata !== 64'h10 || wstrb !== 8'hFF) $display("FAIL wr_payload got %h %h %h exp 0 10 ff", awaddr, wdata, wstrb); else passed++;
    @(negedge clk);
    checks++; if ({awvalid, wvalid, bready, rsp_valid} !== 4'b0010) $display("FAIL wr_resp_phase got %b exp 0010", {awvalid, wvalid, bready, rsp_valid}); else passed++;
    checks++; if (aw_cnt !== 1 || w_cnt !== 1 || aw_addr_seen !== 32'h0 || w_data_seen !== 64'h10 || w_strb_seen !== 8'hFF) $display("FAIL wr_hs got aw%0d w%0d %h %h %h exp aw1 w1 0 10 ff", aw_cnt, w_cnt, aw_addr_seen, w_data_seen, w_strb_seen); else passed++;
    bvalid = 1'b1; bresp = 2'b00;
    @(negedge clk);
    bvalid = 1'b0;
    // Accept, AW/W, B and response occupy four consecutive cycles.
    checks++; if (rsp_valid !== 1'b1) $display("FAIL wr_lat4_rsp_valid got %b exp 1", rsp_valid); else passed++;
    checks++; if ({rsp_write, rsp_resp, bready, cmd_ready} !== 5'b10000 || rsp_rdata !== 64'd0) $display("FAIL wr_rsp got %b rdata %h exp 10000 rdata 0", {rsp_write, rsp_resp, bready, cmd_ready}, rsp_rdata); else passed++;
    checks++; if (b_cnt !== 1 || err_count !== 16'd0) $display("FAIL wr_b_cnt got %0d err %0d exp 1 0", b_cnt, err_count); else passed++;
    consume_rsp();
    checks++; if ({cmd_ready, rsp_valid} !== 2'b10) $display("FAIL wr_back_idle got %b exp 10", {cmd_ready, rsp_valid}); else passed++;
  endtask

  task automatic test_write_w_first();
    clear_counts();
    awready = 1'b0; wready = 1'b1;
    issue_cmd(1'b1, 32'h0001_0008, 64'hA5A5_0000_1234_5678, 8'h0F);
    checks++; if ({awvalid, wvalid} !== 2'b11) $display("FAIL wf_valids got %b exp 11", {awvalid, wvalid}); else passed++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 2) awready = 1'b1;
      checks++; if ({awvalid, wvalid} !== 2'b10 || awaddr !== 32'h0001_0008) $display("FAIL wf_aw_hold%0d got %b addr %h exp 10 addr 00010008", i, {awvalid, wvalid}, awaddr); else passed++;
    end
    @(negedge clk);
    checks++; if ({awvalid, wvalid, bready} !== 3'b001 || aw_cnt !== 1 || w_cnt !== 1) $display("FAIL wf_done got %b aw%0d w%0d exp 001 aw1 w1", {awvalid, wvalid, bready}, aw_cnt, w_cnt); else passed++;
    checks++; if (aw_addr_seen !== 32'h0001_0008 || w_data_seen !== 64'hA5A5_0000_1234_5678 || w_strb_seen !== 8'h0F) $display("FAIL wf_payload got %h %h %h exp 00010008 a5a5000012345678 0f", aw_addr_seen, w_data_seen, w_strb_seen); else passed++;
    bvalid = 1'b1; bresp = 2'b00;
    @(negedge clk);
    // BVALID left high into RSP with an error code must be ignored.
    bresp = 2'b11;
    @(negedge clk);
    checks++; if (b_cnt !== 1 || bready !== 1'b0 || rsp_resp !== 2'b00 || err_count !== 16'd0) $display("FAIL wf_stray_b got b%0d bready %b resp %b err %0d exp b1 0 00 0", b_cnt, bready, rsp_resp, err_count); else passed++;
    bvalid = 1'b0;
    consume_rsp();
    awready = 1'b1;
  endtask

  task automatic test_read_delay();
    clear_counts();
    arready = 1'b1;
    issue_cmd(1'b0, 32'h0000_4000, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
    checks++; if ({arvalid, awvalid, wvalid} !== 3'b100 || araddr !== 32'h0000_4000) $display("FAIL rd_ar got %b addr %h exp 100 addr 00004000", {arvalid, awvalid, wvalid}, araddr); else passed++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if ({arvalid, rready, rsp_valid} !== 3'b010) $display("FAIL rd_wait%0d got %b exp 010", i, {arvalid, rready, rsp_valid}); else passed++;
    end
    rvalid = 1'b1; rdata = 64'h0102_0304_0506_0708; rresp = 2'b00;
    @(negedge clk);
    rvalid = 1'b0; rdata = 64'd0;
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 64'h0102_0304_0506_0708) $display("FAIL rd_data got v%b %h exp v1 0102030405060708", rsp_valid, rsp_rdata); else passed++;
    checks++; if ({rsp_write, rsp_resp, rready} !== 4'b0000 || ar_cnt !== 1 || r_cnt !== 1 || ar_addr_seen !== 32'h4000) $display("FAIL rd_rsp got %b ar%0d r%0d %h exp 0000 ar1 r1 4000", {rsp_write, rsp_resp, rready}, ar_cnt, r_cnt, ar_addr_seen); else passed++;
    consume_rsp();
  endtask

  task automatic test_errors();
    arready = 1'b1; awready = 1'b1; wready = 1'b1;
    issue_cmd(1'b0, 32'h0000_0100, 64'd0, 8'h00);
    @(negedge clk);
    rvalid = 1'b1; rresp = 2'b10; rdata = 64'hDEAD_BEEF_0000_0001;
    @(negedge clk);
    rvalid = 1'b0; rresp = 2'b00;
    checks++; if (err_count !== 16'd1 || rsp_resp !== 2'b10) $display("FAIL err_rd got err %0d resp %b exp 1 10", err_count, rsp_resp); else passed++;
    cmd_valid = 1'b1; cmd_write = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 3) cmd_valid = 1'b0;
      checks++; if ({rsp_valid, rsp_write, rsp_resp, cmd_ready} !== 5'b10100 || rsp_rdata !== 64'hDEAD_BEEF_0000_0001 || err_count !== 16'd1) $display("FAIL err_rd_hold%0d got %b %h err %0d exp 10100 deadbeef00000001 1", i, {rsp_valid, rsp_write, rsp_resp, cmd_ready}, rsp_rdata, err_count); else passed++;
    end
    consume_rsp();
    issue_cmd(1'b1, 32'h0000_0200, 64'h55, 8'h01);
    @(negedge clk);
    bvalid = 1'b1; bresp = 2'b11;
    @(negedge clk);
    bvalid = 1'b0; bresp = 2'b00;
    checks++; if (err_count !== 16'd2 || rsp_resp !== 2'b11 || rsp_write !== 1'b1 || rsp_rdata !== 64'd0) $display("FAIL err_wr got err %0d resp %b wr %b rdata %h exp 2 11 1 0", err_count, rsp_resp, rsp_write, rsp_rdata); else passed++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if ({rsp_valid, rsp_write, rsp_resp, cmd_ready} !== 5'b11110 || err_count !== 16'd2) $display("FAIL err_wr_hold%0d got %b err %0d exp 11110 2", i, {rsp_valid, rsp_write, rsp_resp, cmd_ready}, err_count); else passed++;
    end
    consume_rsp();
  endtask

  task automatic test_reset_mid();
    clear_counts();
    awready = 1'b0; wready = 1'b0;
    issue_cmd(1'b1, 32'h0000_0300, 64'h77, 8'hFF);
    checks++; if (awvalid !== 1'b1 || err_count !== 16'd2) $display("FAIL mid_pre got aw %b err %0d exp 1 2", awvalid, err_count); else passed++;
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({awvalid, wvalid, bready, arvalid, rready, rsp_valid} !== 6'b0 || err_count !== 16'd0) $display("FAIL mid_async got %b err %0d exp 000000 0", {awvalid, wvalid, bready, arvalid, rready, rsp_valid}, err_count); else passed++;
    checks++; if (rsp_rdata !== 64'd0 || rsp_resp !== 2'b00 || rsp_write !== 1'b0) $display("FAIL mid_rsp_clr got %h %b %b exp 0 00 0", rsp_rdata, rsp_resp, rsp_write); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1 || aw_cnt !== 0) $display("FAIL mid_release got rdy %b aw%0d exp 1 0", cmd_ready, aw_cnt); else passed++;
    awready = 1'b1; wready = 1'b1;
    issue_cmd(1'b1, 32'h0000_0400, 64'h99, 8'h3C);
    @(negedge clk);
    bvalid = 1'b1; bresp = 2'b00;
    @(negedge clk);
    bvalid = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_resp !== 2'b00 || aw_cnt !== 1 || w_cnt !== 1 || aw_addr_seen !== 32'h400 || w_data_seen !== 64'h99) $display("FAIL mid_next got v%b resp %b aw%0d w%0d %h %h exp v1 00 aw1 w1 400 99", rsp_valid, rsp_resp, aw_cnt, w_cnt, aw_addr_seen, w_data_seen); else passed++;
    consume_rsp();
    checks++; if (cmd_ready !== 1'b1 || err_count !== 16'd0) $display("FAIL mid_final got rdy %b err %0d exp 1 0", cmd_ready, err_count); else passed++;
  endtask

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
    clear_counts();
    aw_addr_seen = '0; ar_addr_seen = '0; w_data_seen = '0; w_strb_seen = '0;
    test_reset();
    test_write_basic();
    test_write_w_first();
    test_read_delay();
    test_errors();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0d checks", checks);
    $fatal(1, "watchdog");
  end

endmodule
